// File: rtl/key_event_queue.sv
// -----------------------------------------------------------------------------
// key_event_queue
// Decodes a stream of PS/2 set-2 scan-code bytes into key-press events
// {ext, code}, filters typematic repeats and queues the events in a
// first-word fall-through FIFO for a downstream consumer.
//
// Ports
//   clk         rising-edge system clock
//   rst         synchronous active-high reset
//   code_valid  one-cycle strobe marking a received byte on code
//   code        received scan-code byte
//   key_valid   FIFO non-empty, head entry presented on key_code/key_ext
//   key_code    make code at the FIFO head
//   key_ext     head entry was E0-prefixed
//   key_ready   consumer accepts the head entry (pop when key_valid=1)
//   count       number of queued entries, 0..DEPTH
//   overflow    sticky: an event was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module key_event_queue #(
    parameter int DEPTH           = 8,
    parameter int TIMEOUT_CYC     = 1000000,
    parameter bit SUPPRESS_REPEAT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       code_valid,
    input  logic [7:0] code,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    input  logic       key_ready,
    output logic [4:0] count,
    output logic       overflow
);

    localparam int             AW          = $clog2(DEPTH);
    localparam int             TW          = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]  TIMEOUT_VAL = TW'(TIMEOUT_CYC);
    localparam logic [4:0]     DEPTH_VAL   = 5'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_idle_cnt;
    logic [8:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [4:0]      r_count;
    logic            r_overflow;
    logic [8:0]      r_last_key;
    logic            r_last_valid;

    state_t          w_cur_state;
    state_t          w_state_nxt;
    logic            w_timeout;
    logic            w_make;
    logic            w_release;
    logic [8:0]      w_entry;
    logic            w_repeat;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_wr;
    logic            w_drop;
    logic            w_rel_match;
    logic [8:0]      w_head;

    // Decoder next-state: a timed-out prefix is abandoned and the byte arriving
    // in that same cycle is decoded from IDLE rather than as a release.
    always_comb begin
        w_timeout   = (r_state != S_IDLE) && (r_idle_cnt == TIMEOUT_VAL);
        w_cur_state = w_timeout ? S_IDLE : r_state;
        w_state_nxt = w_cur_state;
        w_make      = 1'b0;
        w_release   = 1'b0;
        w_entry     = {1'b0, code};
        if (code_valid) begin
            case (w_cur_state)
                S_IDLE: begin
                    case (code)
                        8'hE0:                      w_state_nxt = S_EXT;
                        8'hF0:                      w_state_nxt = S_BRK;
                        8'h00, 8'hFF, 8'hAA, 8'hFA: w_state_nxt = S_IDLE;
                        default:                    w_make      = 1'b1;
                    endcase
                end
                S_EXT: begin
                    case (code)
                        8'hF0:   w_state_nxt = S_EXT_BRK;
                        8'hE0:   w_state_nxt = S_EXT;
                        default: begin
                            w_make      = 1'b1;
                            w_entry     = {1'b1, code};
                            w_state_nxt = S_IDLE;
                        end
                    endcase
                end
                S_BRK: begin
                    w_release   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                S_EXT_BRK: begin
                    w_release   = 1'b1;
                    w_entry     = {1'b1, code};
                    w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end else begin
            w_state_nxt = w_cur_state;
        end
    end

    // Repeat filter and FIFO handshake qualification.
    always_comb begin
        w_rel_match = r_last_valid && (w_entry == r_last_key);
        w_repeat    = (SUPPRESS_REPEAT != 1'b0) && w_rel_match;
        w_push      = w_make && !w_repeat;
        w_pop       = (r_count != 5'd0) && key_ready;
        w_full      = (r_count == DEPTH_VAL);
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        w_wr        = w_push && (!w_full || w_pop);
        w_drop      = w_push && w_full && !w_pop;
    end

    // Decoder state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Idle counter: cleared by every byte, saturates at the timeout value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle_cnt <= '0;
        end else if (code_valid) begin
            r_idle_cnt <= '0;
        end else if (r_idle_cnt != TIMEOUT_VAL) begin
            r_idle_cnt <= r_idle_cnt + TW'(1);
        end else begin
            r_idle_cnt <= r_idle_cnt;
        end
    end

    // Last-pushed key tracking; dropped (overflowed) events do not update it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_key   <= 9'h000;
            r_last_valid <= 1'b0;
        end else if (w_wr) begin
            r_last_key   <= w_entry;
            r_last_valid <= 1'b1;
        end else if (w_release && w_rel_match) begin
            r_last_valid <= 1'b0;
        end else begin
            r_last_valid <= r_last_valid;
        end
    end

    // FIFO storage and pointers; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 9'h000;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    // Occupancy counter: simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 5'd0;
        end else begin
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else begin
            r_overflow <= r_overflow;
        end
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign key_valid = (r_count != 5'd0);
    assign key_code  = w_head[7:0];
    assign key_ext   = w_head[8];
    assign count     = r_count;
    assign overflow  = r_overflow;

endmodule

// File: doc/key_event_queue.md
KEY_EVENT_QUEUE -- requirements
Module: key_event_queue

Interface
REQ-001 Parameter DEPTH, default 8, number of FIFO entries; SHALL be a power of two from 2 to 16.
REQ-002 Parameter TIMEOUT_CYC, default 1000000, number of idle clk cycles after which a pending prefix is abandoned (10 ms at 100 MHz).
REQ-003 Parameter SUPPRESS_REPEAT, default 1; when 1, typematic auto-repeat make codes are dropped.
REQ-004 clk  input  1  system clock; all logic SHALL be on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 code_valid  input  1  one-cycle strobe, clk-synchronous, marking one received PS/2 byte.
REQ-007 code  input  8  received scan-code byte; valid only while code_valid=1.
REQ-008 key_valid  output  1  FIFO non-empty; the head entry is presented.
REQ-009 key_code  output  8  make code at the FIFO head.
REQ-010 key_ext  output  1  head entry was E0-prefixed (extended key).
REQ-011 key_ready  input  1  consumer accepts the head entry; a pop occurs on a cycle where key_valid=1 and key_ready=1.
REQ-012 count  output  5  current number of FIFO entries, 0..DEPTH.
REQ-013 overflow  output  1  sticky flag: a key event was dropped because the FIFO was full.

Function
REQ-014 Decoder FSM states SHALL be IDLE, EXT, BRK and EXT_BRK, and all transitions SHALL occur only on cycles with code_valid=1, except the timeout in REQ-019.
REQ-015 In IDLE the decoder SHALL act on code as follows:
  - 8'hE0: go to EXT.
  - 8'hF0: go to BRK.
  - 8'h00, 8'hFF, 8'hAA or 8'hFA: discard, stay in IDLE.
  - any other value: push {ext=0, code}.
REQ-016 In EXT the decoder SHALL act on code as follows:
  - 8'hF0: go to EXT_BRK.
  - 8'hE0: stay in EXT.
  - any other value: push {ext=1, code}, return to IDLE.
REQ-017 BRK and EXT_BRK SHALL consume the next byte as a release code, push nothing, and return to IDLE.
REQ-018 The repeat filter SHALL track the last pushed entry {ext, code} in a register last_key, which has a valid bit.
  - When SUPPRESS_REPEAT=1, a make equal to a valid last_key SHALL be dropped.
  - A release whose {ext, code} matches last_key SHALL clear the valid bit.
  - A release that does not match SHALL leave last_key unchanged.
REQ-019 A free-running idle counter SHALL reset on every code_valid; when the FSM is not IDLE and the counter reaches TIMEOUT_CYC, the FSM SHALL return to IDLE without pushing.
REQ-020 FIFO SHALL be first-word fall-through:
  - key_valid, key_code and key_ext SHALL reflect the head directly from registers.
  - A push accepted at rising edge N into an empty FIFO SHALL make key_valid=1 in the cycle following edge N.
REQ-021 The FIFO SHALL handle push, pop and boundary cases as follows:
  - Push with pop in the same cycle: both SHALL occur and count SHALL be unchanged, including when full.
  - Push while full without a pop: the event SHALL be dropped, overflow SHALL be set, and last_key SHALL NOT update.
  - Pop while empty: impossible by definition, and state SHALL be unchanged.
REQ-022 Read and write pointers SHALL be log2(DEPTH) bits wide, wrap modulo DEPTH, and count SHALL never exceed DEPTH.
REQ-023 Head outputs SHALL be held stable while key_valid=1 and key_ready=0.
REQ-024 overflow SHALL clear only on rst.

Reset
REQ-025 When rst=1 at a rising edge, the block SHALL reset to:
  - FSM: IDLE.
  - FIFO: emptied, count=0, key_valid=0.
  - Outputs: key_code=8'h00, key_ext=0, overflow=0.
  - Repeat filter and timer: last_key invalid, idle counter=0.
REQ-026 rst SHALL take priority over code_valid and key_ready in the same cycle.
REQ-027 rst asserted mid-sequence (e.g. after E0 and before the final byte) SHALL discard the partial sequence, and the next byte SHALL be decoded from IDLE.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
  - Basic make/break: bytes 1C, F0, 1C with key_ready=1 -> exactly one event {ext=0, 1C}; key_valid high one cycle after the 1C strobe.
  - Extended key: bytes E0, 75, E0, F0, 75 -> one event {ext=1, 75}; FSM back in IDLE.
  - Repeat: SUPPRESS_REPEAT=1, bytes 23, 23, 23, F0, 23, 23 -> two events 23; with SUPPRESS_REPEAT=0, four events 23.
  - Overflow: key_ready=0, DEPTH=8, nine distinct makes (15, 1D, 24, 2D, 2C, 35, 3C, 43, 44) -> count=8, overflow=1, 44 lost; then drain -> entries come out in order 15 through 43.
  - Full push and pop: FIFO full, simultaneous make 4D and pop -> count stays 8, overflow stays 0, 4D is last out.
  - Timeout and reset: byte F0, then no strobe for TIMEOUT_CYC cycles, then 1C -> 1C pushed; and E0 followed by rst, then 75 -> event {ext=0, 75}.
